// File: rtl/ms_delay_sequencer.sv
// ms_delay_sequencer: turns a programmed ms delay into a done pulse or a
// periodic pulse train by gating the 1 ms timer and counting its ticks.
// Ports: clk, rst (sync, active-high); start/delay_ms/periodic request,
// abort cancel, ms_tick timer pulse; timer_enable, busy, done (1-cycle),
// remaining (ms left in current period). All outputs registered.
module ms_delay_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] delay_ms,
    input  logic             periodic,
    input  logic             abort,
    input  logic             ms_tick,
    output logic             timer_enable,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] rem_n;
    logic [CNT_W-1:0] dly;
    logic [CNT_W-1:0] dly_n;
    logic             per;
    logic             per_n;
    logic             done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            remaining    <= '0;
            dly          <= '0;
            per          <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            timer_enable <= 1'b0;
        end else begin
            state        <= state_n;
            remaining    <= rem_n;
            dly          <= dly_n;
            per          <= per_n;
            done         <= done_n;
            // busy and enable are registered copies of the next state
            busy         <= (state_n == RUN);
            timer_enable <= (state_n == RUN);
        end
    end

    always_comb begin
        state_n = state;
        rem_n   = remaining;
        dly_n   = dly;
        per_n   = per;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                // abort and ms_tick have no meaning while idle
                if (start) begin
                    if (delay_ms != '0) begin
                        state_n = RUN;
                        rem_n   = delay_ms;
                        dly_n   = delay_ms;
                        per_n   = periodic;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            RUN: begin
                // abort outranks any tick, even the expiring one
                if (abort) begin
                    state_n = IDLE;
                    rem_n   = '0;
                end else if (ms_tick) begin
                    if (remaining > ONE) begin
                        rem_n = remaining - ONE;
                    end else if (remaining == ONE) begin
                        done_n = 1'b1;
                        if (per) begin
                            rem_n = dly;
                        end else begin
                            state_n = IDLE;
                            rem_n   = '0;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                rem_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ms_delay_sequencer.sv
// tb_ms_delay_sequencer: directed vectors with hand-computed expectations
// for the ms delay sequencer (one-shot, periodic, abort, zero, reset).
module tb_ms_delay_sequencer;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] delay_ms;
    logic             periodic;
    logic             abort;
    logic             ms_tick;
    logic             timer_enable;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;

    int checks;
    int errors;

    ms_delay_sequencer #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .delay_ms     (delay_ms),
        .periodic     (periodic),
        .abort        (abort),
        .ms_tick      (ms_tick),
        .timer_enable (timer_enable),
        .busy         (busy),
        .done         (done),
        .remaining    (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, obs, exp);
        end
    endtask

    // advance one clock edge; sample point is 1 time unit after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input int en, input int bz,
                        input int dn, input int rm);
        chk({tag, ".en"}, int'(timer_enable), en);
        chk({tag, ".busy"}, int'(busy), bz);
        chk({tag, ".done"}, int'(done), dn);
        chk({tag, ".rem"}, int'(remaining), rm);
    endtask

    task automatic tick();
        ms_tick = 1'b1;
        cyc();
        ms_tick = 1'b0;
    endtask

    task automatic go(input int d, input logic p);
        start    = 1'b1;
        delay_ms = CNT_W'(d);
        periodic = p;
        cyc();
        start    = 1'b0;
        delay_ms = '0;
        periodic = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        delay_ms = '0;
        periodic = 1'b0;
        abort    = 1'b0;
        ms_tick  = 1'b0;

        // 1: reset, ticks ignored in IDLE
        cyc();
        cyc();
        outs("rst", 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        outs("idle_tick", 0, 0, 0, 0);

        // 2: one-shot, 3 ms
        go(3, 1'b0);
        outs("os_start", 1, 1, 0, 3);
        cyc();
        outs("os_gap", 1, 1, 0, 3);
        tick();
        outs("os_t1", 1, 1, 0, 2);
        tick();
        outs("os_t2", 1, 1, 0, 1);
        tick();
        outs("os_t3", 0, 0, 1, 0);
        cyc();
        outs("os_after", 0, 0, 0, 0);

        // 3: periodic, 2 ms, 5 ticks
        go(2, 1'b1);
        outs("per_start", 1, 1, 0, 2);
        for (int i = 1; i <= 5; i++) begin
            tick();
            outs($sformatf("per_t%0d", i), 1, 1,
                 (i % 2 == 0) ? 1 : 0,
                 (i % 2 == 1) ? 1 : 2);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        outs("per_abort", 0, 0, 0, 0);

        // 4: abort together with 2nd tick
        go(4, 1'b0);
        tick();
        outs("ab_t1", 1, 1, 0, 3);
        abort   = 1'b1;
        ms_tick = 1'b1;
        cyc();
        abort   = 1'b0;
        ms_tick = 1'b0;
        outs("ab_t2", 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            outs($sformatf("ab_post%0d", i), 0, 0, 0, 0);
        end

        // abort beats the expiring tick
        go(1, 1'b0);
        abort   = 1'b1;
        ms_tick = 1'b1;
        cyc();
        abort   = 1'b0;
        ms_tick = 1'b0;
        outs("ab_exp", 0, 0, 0, 0);

        // 5: zero delay
        go(0, 1'b1);
        outs("zero", 0, 0, 1, 0);
        cyc();
        outs("zero_after", 0, 0, 0, 0);

        // start with abort in IDLE: start wins
        abort = 1'b1;
        go(2, 1'b0);
        abort = 1'b0;
        outs("st_ab", 1, 1, 0, 2);
        tick();
        tick();
        outs("st_ab_end", 0, 0, 1, 0);

        // 6: restart attempt during RUN is ignored
        go(5, 1'b0);
        outs("rs_start", 1, 1, 0, 5);
        go(9, 1'b1);
        outs("rs_ign", 1, 1, 0, 5);
        for (int i = 1; i <= 5; i++) begin
            tick();
            outs($sformatf("rs_t%0d", i),
                 (i < 5) ? 1 : 0, (i < 5) ? 1 : 0,
                 (i == 5) ? 1 : 0, 5 - i);
        end
        cyc();
        outs("rs_after", 0, 0, 0, 0);

        // reset at tick 3 of a new run
        go(5, 1'b1);
        tick();
        tick();
        outs("rr_t2", 1, 1, 0, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        outs("rr_rst", 0, 0, 0, 0);
        tick();
        tick();
        outs("rr_post", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
